smg_scan_display: RTL and testbench

- Multi-digit, time-multiplexed seven-segment driver. Successor to the single-digit registered hex encoder.
- Latches a packed hex word, per-digit decimal points and a blank mask on a load strobe, then scans the digits.
- Per digit slot: drives one common line and that digit's segment pattern. Adds anti-ghost blanking and optional leading-zero suppression.
- Sits between the CPU debug/IO bus and the board's seven-segment header.

---
 rtl/smg_pkg.sv | 11 +
 rtl/smg_scan_timer.sv | 26 ++
 rtl/smg_scan_display.sv | 73 +++++++
 tb/tb_smg_scan_display.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// smg_pkg: seven-segment code table and encoder shared by the scan display.
package smg_pkg;
  localparam logic [7:0] SEG_OFF_AL = 8'hFF;
  localparam logic [15:0][7:0] SEG_CODES = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp);
    return dp ? (SEG_CODES[nibble] & 8'h7F) : SEG_CODES[nibble];
  endfunction
endpackage

// File: rtl/smg_scan_timer.sv
// smg_scan_timer: slot prescaler, digit index and slot-advance pulse.
module smg_scan_timer #(
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  localparam int CW = $clog2(SCAN_DIV),
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1
)(
  input  logic          CLK,
  input  logic          RSTn,
  output logic [CW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          slot_start
);
  logic tc;
  assign tc = cnt == CW'(SCAN_DIV - 1);
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      cnt        <= '0;
      idx        <= '0;
      slot_start <= 1'b0;
    end else begin
      cnt        <= tc ? '0 : cnt + 1'b1;
      idx        <= !tc ? idx : (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      slot_start <= tc;
    end
endmodule

// File: rtl/smg_scan_display.sv
// smg_scan_display: latched multi-digit hex value scanned onto a multiplexed
// seven-segment header with anti-ghost blanking and leading-zero suppression.
module smg_scan_display import smg_pkg::*; #(
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYCLES = 1,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit SCAN_ACTIVE_LOW = 1,
  parameter bit LZ_BLANK = 0
)(
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Number_Data,
  input  logic [DIGITS-1:0]     Dp_In,
  input  logic [DIGITS-1:0]     Blank_Mask,
  output logic [7:0]            SMG_Data,
  output logic [DIGITS-1:0]     SMG_Scan,
  output logic                  Slot_Start
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;
  localparam logic [DIGITS-1:0] SCAN_OFF = {DIGITS{SCAN_ACTIVE_LOW}};

  logic [DIGITS-1:0][3:0] num_q;
  logic [DIGITS-1:0]      dp_q, mask_q, lz, onehot;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   slot_tick, all_zero, blank, dark;
  logic [7:0]             seg_al;

  smg_scan_timer #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_timer (
    .CLK(CLK), .RSTn(RSTn), .cnt(cnt), .idx(idx), .slot_start(slot_tick)
  );

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      num_q  <= '0;
      dp_q   <= '0;
      mask_q <= '0;
    end else if (Load) begin
      num_q  <= Number_Data;
      dp_q   <= Dp_In;
      mask_q <= Blank_Mask;
    end

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lz = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero && (num_q[i] == 4'd0);
      lz[i] = all_zero;
    end
  end

  assign blank  = int'(cnt) < BLANK_CYCLES;
  assign dark   = mask_q[idx] || (LZ_BLANK && lz[idx]);
  assign seg_al = (blank || dark) ? SEG_OFF_AL : seg_encode(num_q[idx], dp_q[idx]);
  assign onehot = DIGITS'(1) << idx;

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      SMG_Data   <= SEG_OFF;
      SMG_Scan   <= SCAN_OFF;
      Slot_Start <= 1'b0;
    end else begin
      SMG_Data   <= SEG_ACTIVE_LOW ? seg_al : ~seg_al;
      SMG_Scan   <= blank ? SCAN_OFF : SCAN_ACTIVE_LOW ? ~onehot : onehot;
      Slot_Start <= slot_tick;
    end
endmodule

// File: tb/tb_smg_scan_display.sv
// tb_smg_scan_display: directed checks of scan order, dp/mask, LZ, load timing and reset.
module tb_smg_scan_display;
  logic        CLK = 1'b0, RSTn = 1'b0, Load = 1'b0;
  logic [15:0] Number_Data = '0;
  logic [3:0]  Dp_In = '0, Blank_Mask = '0;
  logic [7:0]  smg_data, lz_data;
  logic [3:0]  smg_scan, lz_scan;
  logic        slot_start, lz_slot;
  int          n_run = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  smg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1),
                     .SCAN_ACTIVE_LOW(1), .LZ_BLANK(0)) u_dut (
    .CLK(CLK), .RSTn(RSTn), .Load(Load), .Number_Data(Number_Data), .Dp_In(Dp_In),
    .Blank_Mask(Blank_Mask), .SMG_Data(smg_data), .SMG_Scan(smg_scan), .Slot_Start(slot_start)
  );

  smg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1),
                     .SCAN_ACTIVE_LOW(1), .LZ_BLANK(1)) u_lz (
    .CLK(CLK), .RSTn(RSTn), .Load(Load), .Number_Data(Number_Data), .Dp_In(Dp_In),
    .Blank_Mask(Blank_Mask), .SMG_Data(lz_data), .SMG_Scan(lz_scan), .Slot_Start(lz_slot)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] mk);
    @(negedge CLK);
    Number_Data = d;
    Dp_In = dp;
    Blank_Mask = mk;
    Load = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
  endtask

  // Lands on the first cycle of the digit-0 slot (the cycle after digit 3 was shown).
  task automatic sync(input bit lz);
    logic [3:0] prev;
    bit ok;
    ok = 1'b0;
    prev = lz ? lz_scan : smg_scan;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if ((lz ? lz_slot : slot_start) && prev == 4'b0111) ok = 1'b1;
      prev = lz ? lz_scan : smg_scan;
    end
    chk("sync", 32'(ok), 32'd1);
  endtask

  task automatic frame(input bit lz, input logic [31:0] exp);
    logic [7:0] ed;
    logic [3:0] es, one;
    bit blk;
    sync(lz);
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 4; p++) begin
        if (s != 0 || p != 0) @(negedge CLK);
        blk = !lz && p == 0;
        one = 4'b0001 << s;
        ed = blk ? 8'hFF : exp[8*s +: 8];
        es = blk ? 4'b1111 : ~one;
        chk($sformatf("slot%0d.%0d data", s, p), lz ? lz_data : smg_data, ed);
        chk($sformatf("slot%0d.%0d scan", s, p), lz ? lz_scan : smg_scan, es);
        chk($sformatf("slot%0d.%0d start", s, p), lz ? lz_slot : slot_start, 32'(p == 0));
      end
  endtask

  initial begin
    #22;
    chk("rst data", smg_data, 8'hFF);
    chk("rst scan", smg_scan, 4'b1111);
    chk("rst start", slot_start, 1'b0);
    chk("rst lz data", lz_data, 8'hFF);
    chk("rst lz scan", lz_scan, 4'b1111);
    @(negedge CLK) RSTn = 1'b1;
    @(negedge CLK);
    chk("rel blank data", smg_data, 8'hFF);
    chk("rel blank scan", smg_scan, 4'b1111);
    chk("rel start", slot_start, 1'b0);
    chk("rel lz data", lz_data, 8'hC0);
    @(negedge CLK);
    chk("rel d0 data", smg_data, 8'hC0);
    chk("rel d0 scan", smg_scan, 4'b1110);

    load(16'h1A3F, 4'b0000, 4'b0000);
    frame(1'b0, {8'hF9, 8'h88, 8'hB0, 8'h8E});
    @(negedge CLK);
    chk("wrap blank scan", smg_scan, 4'b1111);
    chk("wrap start", slot_start, 1'b1);
    @(negedge CLK);
    chk("wrap d0 data", smg_data, 8'h8E);
    chk("wrap d0 scan", smg_scan, 4'b1110);

    load(16'h8888, 4'b0010, 4'b1000);
    frame(1'b0, {8'hFF, 8'h80, 8'h00, 8'h80});

    load(16'h0050, 4'b0100, 4'b0000);
    frame(1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0});
    load(16'h0000, 4'b0000, 4'b0000);
    frame(1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0});

    // Load sampled on the edge that first presents digit 1.
    sync(1'b1);
    repeat (3) @(negedge CLK);
    Number_Data = 16'h0050;
    Load = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    chk("edge old data", lz_data, 8'hFF);
    chk("edge old scan", lz_scan, 4'b1101);
    chk("edge start", lz_slot, 1'b1);
    @(negedge CLK);
    chk("edge new data", lz_data, 8'h92);

    load(16'h1A3F, 4'b0000, 4'b0000);
    sync(1'b0);
    repeat (9) @(negedge CLK);
    chk("pre-rst d2 data", smg_data, 8'h88);
    chk("pre-rst d2 scan", smg_scan, 4'b1011);
    #2 RSTn = 1'b0;
    #1;
    chk("async rst data", smg_data, 8'hFF);
    chk("async rst scan", smg_scan, 4'b1111);
    chk("async rst start", slot_start, 1'b0);
    @(negedge CLK) RSTn = 1'b1;
    @(negedge CLK);
    chk("restart blank scan", smg_scan, 4'b1111);
    chk("restart start", slot_start, 1'b0);
    @(negedge CLK);
    chk("restart d0 data", smg_data, 8'hC0);
    chk("restart d0 scan", smg_scan, 4'b1110);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
